// File: rtl/inst_encoder_writer_if.sv
// Request/memory-write bundle for inst_encoder_writer: decoded fields in, encoded word out.
interface inst_encoder_writer_if #(
  parameter int INST_WIDTH = 32,
  parameter int IMM_WIDTH  = 64,
  parameter int ADDR_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            fmt;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [4:0]            rd;
  logic [4:0]            rs1;
  logic [4:0]            rs2;
  logic [IMM_WIDTH-1:0]  imm;
  logic                  addr_clr;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [INST_WIDTH-1:0] mem_wdata;
  logic                  err;
  logic [ADDR_WIDTH:0]   wr_count;

  modport master (
    output in_valid, fmt, funct3, funct7, rd, rs1, rs2, imm, addr_clr,
    input  in_ready, mem_we, mem_addr, mem_wdata, err, wr_count
  );

  modport slave (
    input  in_valid, fmt, funct3, funct7, rd, rs1, rs2, imm, addr_clr,
    output in_ready, mem_we, mem_addr, mem_wdata, err, wr_count
  );
endinterface

// File: rtl/inst_encoder_writer.sv
// Re-encodes decoded I/S/B/R fields into RV64 instruction words and writes them
// sequentially into instruction memory, rejecting out-of-range immediates.
//
// state  | meaning
// IDLE   | in_ready high, waiting for a request
// ENCODE | range check, word registered
// WRITE  | mem_we pulse at the write pointer
// ERR    | err pulse, nothing written
module inst_encoder_writer #(
  parameter int INST_WIDTH = 32,
  parameter int IMM_WIDTH  = 64,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  inst_encoder_writer_if.slave  bus
);

  localparam logic [6:0] OP_I = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;
  localparam logic [6:0] OP_R = 7'b0110011;

  typedef enum logic [1:0] {IDLE, ENCODE, WRITE, ERR} state_t;

  state_t                state_q, state_d;
  logic [1:0]            fmt_q;
  logic [2:0]            f3_q;
  logic [6:0]            f7_q;
  logic [4:0]            rd_q, rs1_q, rs2_q;
  logic [IMM_WIDTH-1:0]  imm_q;
  logic [INST_WIDTH-1:0] word, wdata_q;
  logic                  range_ok, i_ok, b_ok;
  logic [ADDR_WIDTH-1:0] ptr_q, addr_hold_q;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic                  accept;

  assign accept = (state_q == IDLE) && bus.in_valid;

  // 12-bit (I/S) and 13-bit even (B) signed ranges: upper bits must be pure sign copies
  assign i_ok = (&imm_q[IMM_WIDTH-1:11]) | ~(|imm_q[IMM_WIDTH-1:11]);
  assign b_ok = ((&imm_q[IMM_WIDTH-1:12]) | ~(|imm_q[IMM_WIDTH-1:12])) & ~imm_q[0];

  always_comb begin
    word     = '0;
    range_ok = 1'b1;
    case (fmt_q)
      2'd0: begin
        word     = {imm_q[11:0], rs1_q, f3_q, rd_q, OP_I};
        range_ok = i_ok;
      end
      2'd1: begin
        word     = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], OP_S};
        range_ok = i_ok;
      end
      2'd2: begin
        word     = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q, imm_q[4:1], imm_q[11], OP_B};
        range_ok = b_ok;
      end
      default: begin
        word     = {f7_q, rs2_q, rs1_q, f3_q, rd_q, OP_R};
        range_ok = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = ENCODE;
      ENCODE:  state_d = range_ok ? WRITE : ERR;
      WRITE:   state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      fmt_q       <= '0;
      f3_q        <= '0;
      f7_q        <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      wdata_q     <= '0;
      ptr_q       <= '0;
      addr_hold_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        fmt_q <= bus.fmt;
        f3_q  <= bus.funct3;
        f7_q  <= bus.funct7;
        rd_q  <= bus.rd;
        rs1_q <= bus.rs1;
        rs2_q <= bus.rs2;
        imm_q <= bus.imm;
      end
      if (state_q == ENCODE && range_ok) wdata_q <= word;
      if (state_q == WRITE) begin
        addr_hold_q <= ptr_q;
        if (~&cnt_q) cnt_q <= cnt_q + 1'b1;
      end
      // clear beats the post-write increment; the write itself already used the old pointer
      if (bus.addr_clr)            ptr_q <= '0;
      else if (state_q == WRITE)   ptr_q <= ptr_q + 1'b1;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.mem_we    = (state_q == WRITE);
  assign bus.err       = (state_q == ERR);
  assign bus.mem_addr  = (state_q == WRITE) ? ptr_q : addr_hold_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.wr_count  = cnt_q;

endmodule

// File: tb/tb_inst_encoder_writer.sv
// Scoreboard bench for inst_encoder_writer: driver pushes expected writes/errors,
// monitor pops and compares whenever mem_we or err is seen.
module tb_inst_encoder_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_encoder_writer_if #(.INST_WIDTH(32), .IMM_WIDTH(64), .ADDR_WIDTH(8)) bus ();

  inst_encoder_writer #(.INST_WIDTH(32), .IMM_WIDTH(64), .ADDR_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          is_err;
    logic [7:0]  addr;
    logic [31:0] w;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int m_ptr = 0;
  int m_cnt = 0;
  logic [7:0]  m_last_addr = '0;
  logic [31:0] m_last_w = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder: range by signed value comparisons, fields by arithmetic shifts.
  function automatic logic [31:0] enc(input int f, input int f3, input int f7, input int rd,
                                      input int rs1, input int rs2, input longint imm,
                                      output bit bad);
    longint t;
    bad = 1'b0;
    t = 0;
    case (f)
      0: begin
        bad = (imm < -2048) || (imm > 2047);
        t = ((imm & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h03;
      end
      1: begin
        bad = (imm < -2048) || (imm > 2047);
        t = (((imm >>> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
            | ((imm & 'h1F) << 7) | 'h23;
      end
      2: begin
        bad = (imm < -4096) || (imm > 4094) || (imm % 2 != 0);
        t = (((imm >>> 12) & 1) << 31) | (((imm >>> 5) & 'h3F) << 25) | (rs2 << 20)
            | (rs1 << 15) | (f3 << 12) | (((imm >>> 1) & 'hF) << 8)
            | (((imm >>> 11) & 1) << 7) | 'h63;
      end
      default: t = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h33;
    endcase
    return t[31:0];
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) chk("in_ready_timeout", {63'd0, bus.in_ready}, 64'd1);
  endtask

  task automatic send(input int f, input int f3, input int f7, input int rd, input int rs1,
                      input int rs2, input longint imm, input bit clr,
                      input bit has_exp, input logic [31:0] exp_w);
    exp_t e;
    bit bad;
    logic [31:0] w;
    wait_ready();
    bus.fmt = 2'(f); bus.funct3 = 3'(f3); bus.funct7 = 7'(f7);
    bus.rd = 5'(rd); bus.rs1 = 5'(rs1); bus.rs2 = 5'(rs2); bus.imm = 64'(imm);
    bus.in_valid = 1'b1;
    w = enc(f, f3, f7, rd, rs1, rs2, imm, bad);
    e.is_err = bad;
    e.addr   = 8'(m_ptr);
    e.w      = has_exp ? exp_w : w;
    q.push_back(e);
    if (!bad) begin
      m_last_addr = 8'(m_ptr);
      m_last_w    = e.w;
      m_ptr = clr ? 0 : (m_ptr + 1) % 256;
      if (m_cnt < 511) m_cnt++;
    end else if (clr) m_ptr = 0;
    @(negedge clk);
    // garbage while busy must not disturb the accepted request
    bus.fmt = 2'($urandom); bus.funct3 = 3'($urandom); bus.funct7 = 7'($urandom);
    bus.rd = 5'($urandom); bus.rs1 = 5'($urandom); bus.rs2 = 5'($urandom);
    bus.imm = {$urandom, $urandom};
    @(negedge clk);
    bus.addr_clr = clr;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.addr_clr = 1'b0;
    chk("wr_count", {55'd0, bus.wr_count}, 64'(m_cnt));
    chk("mem_addr_hold", {56'd0, bus.mem_addr}, {56'd0, m_last_addr});
    chk("mem_wdata_hold", {32'd0, bus.mem_wdata}, {32'd0, m_last_w});
  endtask

  function automatic longint rand_imm();
    longint b[10];
    b = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098, 4096, 0};
    case ($urandom_range(0, 3))
      0:       return longint'($urandom_range(0, 4095)) - 2048;
      1:       return longint'($urandom_range(0, 8191)) - 4096;
      2:       return longint'({$urandom, $urandom});
      default: return b[$urandom_range(0, 9)];
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (bus.mem_we === 1'b1 || bus.err === 1'b1) begin
      if (bus.mem_we === 1'b1 && bus.err === 1'b1) chk("we_and_err", 64'd1, 64'd0);
      if (q.size() == 0) begin
        chk("unexpected_output", {62'd0, bus.mem_we, bus.err}, 64'd0);
      end else begin
        e = q.pop_front();
        chk("err", {63'd0, bus.err}, {63'd0, e.is_err});
        if (!e.is_err) begin
          chk("mem_addr", {56'd0, bus.mem_addr}, {56'd0, e.addr});
          chk("mem_wdata", {32'd0, bus.mem_wdata}, {32'd0, e.w});
        end
      end
    end
  end

  initial begin
    int n;
    bus.in_valid = 1'b0; bus.addr_clr = 1'b0;
    bus.fmt = '0; bus.funct3 = '0; bus.funct7 = '0;
    bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0; bus.imm = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("rst_mem_we", {63'd0, bus.mem_we}, 64'd0);
    chk("rst_err", {63'd0, bus.err}, 64'd0);
    chk("rst_mem_addr", {56'd0, bus.mem_addr}, 64'd0);
    chk("rst_mem_wdata", {32'd0, bus.mem_wdata}, 64'd0);
    chk("rst_wr_count", {55'd0, bus.wr_count}, 64'd0);

    send(0, 6, 0, 28, 20, 0, 64'h65E, 0, 1, 32'h65EA6E03);
    send(1, 3, 0, 0, 2, 5, -8, 0, 1, 32'hFE513C23);
    send(2, 0, 0, 0, 1, 2, 8, 0, 1, 32'h00208463);
    send(2, 0, 0, 0, 1, 2, 3, 0, 0, 32'h0);
    send(3, 6, 'h72, 28, 20, 30, -1, 0, 1, 32'hE5EA6E33);
    send(0, 0, 0, 1, 1, 0, 2048, 0, 0, 32'h0);
    send(0, 0, 0, 1, 1, 0, -2048, 0, 0, 32'h0);
    send(0, 2, 0, 3, 4, 0, 100, 1, 0, 32'h0);
    chk("clr_ptr_model", 64'(m_ptr), 64'd0);
    send(0, 2, 0, 3, 4, 0, 5, 0, 0, 32'h0);

    n = 0;
    while (m_cnt < 280 && n < 2000) begin
      send($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 127),
           $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
           rand_imm(), ($urandom_range(0, 49) == 0), 0, 32'h0);
      n++;
    end

    wait_ready();
    bus.fmt = 2'd0; bus.funct3 = 3'd1; bus.rd = 5'd2; bus.rs1 = 5'd3; bus.imm = 64'd7;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0; m_cnt = 0; m_last_addr = '0; m_last_w = '0;
    chk("enc_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("enc_rst_mem_we", {63'd0, bus.mem_we}, 64'd0);
    chk("enc_rst_err", {63'd0, bus.err}, 64'd0);
    chk("enc_rst_mem_addr", {56'd0, bus.mem_addr}, 64'd0);
    chk("enc_rst_mem_wdata", {32'd0, bus.mem_wdata}, 64'd0);
    chk("enc_rst_wr_count", {55'd0, bus.wr_count}, 64'd0);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 520; i++)
      send(3, $urandom_range(0, 7), $urandom_range(0, 127), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 31), rand_imm(), 0, 0, 32'h0);
    chk("wr_count_sat", {55'd0, bus.wr_count}, 64'd511);

    repeat (5) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_encoder_writer.md
Name: inst_encoder_writer

Overview:
Converts decoded instruction fields (format, registers, funct, 64-bit sign-extended immediate) back into 32-bit RV64 instruction words and writes them sequentially into instruction memory. It is the inverse of the immediate generator: it scatters the immediate into I/S/B/R field positions and enforces range and alignment. It sits between the test/program-loader side and the instruction memory write port.

Parameters:
INST_WIDTH, 32, instruction word width (fixed encoding layout)
IMM_WIDTH, 64, width of sign-extended immediate input (2*INST_WIDTH)
ADDR_WIDTH, 8, word-address width of memory write pointer

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  request holds valid fields
in_ready  out  1  block can accept a request
fmt  in  2  0=I load, 1=S store, 2=B branch, 3=R arithmetic
funct3  in  3  funct3 field
funct7  in  7  funct7 field (R only)
rd  in  5  destination register (I, R)
rs1  in  5  source 1 (all formats)
rs2  in  5  source 2 (S, B, R)
imm  in  IMM_WIDTH  sign-extended immediate (ignored for R)
addr_clr  in  1  clear write pointer to 0
mem_we  out  1  memory write strobe, one cycle
mem_addr  out  ADDR_WIDTH  write word address
mem_wdata  out  INST_WIDTH  encoded instruction
err  out  1  one-cycle pulse: request rejected
wr_count  out  ADDR_WIDTH+1  number of successful writes since reset, saturating

Behaviour:
- Reset: state IDLE, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, err=0, wr_count=0, write pointer=0. Reset mid-operation aborts any pending write; no mem_we is issued.
- FSM: IDLE -> ENCODE -> WRITE or ERR -> IDLE.
  - IDLE: in_ready=1. in_valid&in_ready at edge N registers all fields; next state is ENCODE.
  - ENCODE (cycle N+1): in_ready=0; range check; word built into a register.
  - WRITE (N+2): mem_we=1, mem_addr=pointer, mem_wdata=word; pointer+1 at edge; wr_count+1 (saturates at all-ones).
  - ERR (N+2): err=1, mem_we=0, pointer and wr_count unchanged.
- Throughput: one request per 3 cycles; in_ready is high only in IDLE.
- Opcodes: I=0000011, S=0100011, B=1100011, R=0110011.
- Encoding (msb..lsb):
  - I: imm[11:0] rs1 funct3 rd op
  - S: imm[11:5] rs2 rs1 funct3 imm[4:0] op
  - B: imm[12] imm[10:5] rs2 rs1 funct3 imm[4:1] imm[11] op
  - R: funct7 rs2 rs1 funct3 rd op
- Range rules (error if violated):
  - I/S: imm[63:11] all equal (range -2048..2047).
  - B: imm[63:12] all equal and imm[0]=0 (even, -4096..4094).
  - R: never errors; imm is ignored.
- mem_addr/mem_wdata hold their last values outside WRITE.
- Pointer wraps from 2^ADDR_WIDTH-1 to 0 silently; wr_count keeps counting.
- addr_clr: pointer=0 at the next edge in any state. If asserted in the WRITE cycle, the write still uses the old address, and clear wins over the increment (pointer=0).
- in_valid is ignored when in_ready=0; fields need only be stable at the accepting edge.

Test Plan:
- I: fmt=0, rs1=20, funct3=6, rd=28, imm=0x65E -> mem_we at accept+2, mem_addr=0, mem_wdata=0x65EA6E03, wr_count=1.
- S: fmt=1, rs2=5, rs1=2, funct3=3, imm=-8 -> mem_wdata=0xFE513C23, mem_addr=1.
- B: fmt=2, rs1=1, rs2=2, funct3=0, imm=8 -> mem_wdata=0x00208463. Then B with imm=3 -> err pulse, no mem_we, pointer unchanged.
- R: fmt=3, funct7=0x72, rs2=30, rs1=20, funct3=6, rd=28, imm=0xFFFF_FFFF_FFFF_FFFF -> mem_wdata=0xE5EA6E33, no err.
- Range/wrap: I with imm=2048 -> err. I with imm=-2048 -> accepted. 256 valid writes -> mem_addr goes 255 then 0.
- Control: addr_clr coincident with WRITE at addr 5 -> write to 5, next write to 0. rst asserted in ENCODE -> no mem_we, all outputs at reset values, in_ready=1 the next cycle.
